multi_alarm_controller: RTL and testbench
=========================================

Name: multi_alarm_controller

Overview:
Parametrised successor to the single-alarm controller in the alarm clock. Holds NUM_ALARMS independent alarm times in BCD and edits the selected one. Compares each alarm against the running time of day. Runs a per-channel ring/snooze/timeout state machine and drives a combined alarm-on output to the buzzer/LED logic.

Parameters:
NUM_ALARMS, 4, number of alarm channels (1..8)
SNOOZE_MINUTES, 9, snooze length in minutes (1..59)
RING_TIMEOUT_S, 60, seconds a channel rings before auto-dismiss (1..3599)
SEL_W, $clog2(NUM_ALARMS) min 1, width of the channel select

Ports:
i_Clk  in  1  system clock (5 MHz domain)
i_Reset  in  1  synchronous, active-high reset
i_Sec_Pulse  in  1  one-cycle pulse, once per second
i_Time_Hours  in  8  current hours, BCD 00-23
i_Time_Minutes  in  8  current minutes, BCD 00-59
i_Time_Seconds  in  8  current seconds, BCD 00-59
i_Sel  in  SEL_W  channel targeted by edit and enable-toggle inputs
i_Minutes_Inc / i_Minutes_Dec / i_Hours_Inc / i_Hours_Dec  in  1 each  one-cycle edit pulses
i_Enable_Toggle  in  1  one-cycle pulse; toggles enable of channel i_Sel
i_Snooze  in  1  one-cycle pulse; snoozes all ringing channels
i_Dismiss  in  1  one-cycle pulse; dismisses all ringing and snoozed channels
o_Sel_Hours  out  8  BCD hours of channel i_Sel (combinational mux)
o_Sel_Minutes  out  8  BCD minutes of channel i_Sel
o_Enabled  out  NUM_ALARMS  per-channel enable
o_Ringing  out  NUM_ALARMS  per-channel state==RINGING
o_Alarm_On  out  1  OR of o_Ringing
o_Snoozing  out  1  any channel in SNOOZED

Behaviour:
- Reset: all alarm times 00:00, o_Enabled=0, all channels IDLE, counters 0. o_Ringing=0, o_Alarm_On=0, o_Snoozing=0.
- Alarm time is stored as 24-hour BCD. Edits apply only to channel i_Sel and take effect in the next cycle.
- Minutes wrap 59->00 on inc and 00->59 on dec. Hours wrap 23->00 and 00->23. Minute wrap never carries into hours.
- Inc and dec on the same field in the same cycle: no change. Minute and hour edits in the same cycle both apply.
- If i_Sel >= NUM_ALARMS, edits and toggles are ignored and o_Sel_* read 00.
- Per-channel FSM with states IDLE, RINGING, SNOOZED and a shared-width seconds counter (wide enough for max(SNOOZE_MINUTES*60, RING_TIMEOUT_S)).
- IDLE -> RINGING requires all of: i_Sec_Pulse=1, enabled, i_Time_Seconds==00, and hours and minutes equal to the alarm. Counter loads RING_TIMEOUT_S. Registered, so o_Ringing rises 1 cycle after the matching pulse.
- RINGING:
  - Each i_Sec_Pulse decrements the counter.
  - When the counter reaches 0 on a pulse -> IDLE (auto-dismiss).
  - i_Snooze -> SNOOZED, counter loads SNOOZE_MINUTES*60.
  - i_Dismiss -> IDLE.
- SNOOZED:
  - Each i_Sec_Pulse decrements the counter.
  - When it reaches 0 -> RINGING, counter reloads RING_TIMEOUT_S.
  - i_Dismiss -> IDLE.
  - i_Snooze has no effect.
- Priority within a cycle: i_Reset > disable (toggle to 0) > i_Dismiss > i_Snooze > counter expiry > trigger.
- Disabling a channel forces it to IDLE. Enabling never triggers retroactively: a match needs a later seconds==00 pulse.
- A channel already RINGING or SNOOZED ignores a new match.
- Editing a ringing or snoozed channel's time does not change its state.
- Multiple channels may trigger in the same cycle; each rings independently. Snooze and dismiss act on all channels.
- After dismiss within the matching minute, the channel does not re-trigger, because seconds is no longer 00.

Decomposition:
- Package alarm_clock_pkg:
  - state enum {IDLE, RINGING, SNOOZED}
  - BCD constants (MIN_MAX=8'h59, HR_MAX=8'h23)
  - bcd_inc/bcd_dec wrap functions
  - SNOOZE/timeout counter width function
- Sub-module alarm_channel, instantiated NUM_ALARMS times in a generate loop. It owns one time register pair, the enable bit, the FSM and the counter.
- The top level holds only decode, the select mux and the OR reductions.

Test Plan:
- Reset, then i_Minutes_Inc x61 on channel 0 -> o_Sel_Minutes=8'h01 and o_Sel_Hours=8'h00. i_Hours_Dec once -> 8'h23.
- Channel 2 set to 07:30 and enabled. Drive time 07:30:00 with i_Sec_Pulse -> o_Ringing=4'b0100 and o_Alarm_On=1 one cycle later. Channel 1 at 07:30 but disabled stays 0.
- Ringing, then i_Snooze -> o_Ringing=0 and o_Snoozing=1. After exactly 540 sec pulses (SNOOZE_MINUTES=9) -> o_Ringing[2]=1 again; at 539 pulses still 0.
- Ringing with no input -> after 60 sec pulses o_Ringing=0 and o_Snoozing=0 (auto-dismiss). No re-trigger at 07:31:00.
- Channels 0 and 3 both at 12:00 and enabled -> both ring. i_Dismiss and i_Snooze in the same cycle -> both IDLE (dismiss wins).
- Mid-ring i_Reset=1 for one cycle -> all outputs 0, all alarm times 00:00, o_Enabled=0 on the next cycle.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// Shared types and BCD helpers for the multi-alarm controller.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_t;

  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  // Increment a two-digit BCD value, wrapping from max_val to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_val);
    logic [7:0] res;
    if (val == max_val)
      res = 8'h00;
    else if (val[3:0] == 4'd9)
      res = {val[7:4] + 4'd1, 4'd0};
    else
      res = {val[7:4], val[3:0] + 4'd1};
    return res;
  endfunction

  // Decrement a two-digit BCD value, wrapping from 00 to max_val.
  function automatic logic [7:0] bcd_dec(input logic [7:0] val, input logic [7:0] max_val);
    logic [7:0] res;
    if (val == 8'h00)
      res = max_val;
    else if (val[3:0] == 4'd0)
      res = {val[7:4] - 4'd1, 4'd9};
    else
      res = {val[7:4], val[3:0] - 4'd1};
    return res;
  endfunction

  // Counter width able to hold both the snooze length and the ring timeout in seconds.
  function automatic int cnt_width(input int snooze_min, input int timeout_s);
    int max_s;
    max_s = (snooze_min * 60 > timeout_s) ? snooze_min * 60 : timeout_s;
    return $clog2(max_s + 1);
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored BCD time, enable bit, ring/snooze state and seconds counter.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for a seconds==00 pulse matching the stored time
//   RINGING | alarm active; counter holds seconds left before auto-dismiss
//   SNOOZED | silenced; counter holds seconds left until ringing resumes
module alarm_channel
  import alarm_clock_pkg::*;
#(
  parameter int SNOOZE_MINUTES = 9,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Sec_Pulse,
  input  logic [7:0] i_Time_Hours,
  input  logic [7:0] i_Time_Minutes,
  input  logic [7:0] i_Time_Seconds,
  input  logic       i_Selected,
  input  logic       i_Minutes_Inc,
  input  logic       i_Minutes_Dec,
  input  logic       i_Hours_Inc,
  input  logic       i_Hours_Dec,
  input  logic       i_Enable_Toggle,
  input  logic       i_Snooze,
  input  logic       i_Dismiss,
  output logic [7:0] o_Hours,
  output logic [7:0] o_Minutes,
  output logic       o_Enabled,
  output logic       o_Ringing,
  output logic       o_Snoozing
);

  localparam int              CNT_W      = cnt_width(SNOOZE_MINUTES, RING_TIMEOUT_S);
  localparam logic [CNT_W-1:0] RING_LOAD  = CNT_W'(RING_TIMEOUT_S);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_MINUTES * 60);

  alarm_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             disable_now;
  logic             match;

  assign disable_now = i_Selected && i_Enable_Toggle && o_Enabled;
  assign match       = i_Sec_Pulse && o_Enabled && (i_Time_Seconds == 8'h00) &&
                       (i_Time_Hours == o_Hours) && (i_Time_Minutes == o_Minutes);

  // Alarm time edits and enable toggle for the selected channel.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Hours   <= 8'h00;
      o_Minutes <= 8'h00;
      o_Enabled <= 1'b0;
    end else if (i_Selected) begin
      if (i_Minutes_Inc && !i_Minutes_Dec)
        o_Minutes <= bcd_inc(o_Minutes, MIN_MAX);
      else if (i_Minutes_Dec && !i_Minutes_Inc)
        o_Minutes <= bcd_dec(o_Minutes, MIN_MAX);
      if (i_Hours_Inc && !i_Hours_Dec)
        o_Hours <= bcd_inc(o_Hours, HR_MAX);
      else if (i_Hours_Dec && !i_Hours_Inc)
        o_Hours <= bcd_dec(o_Hours, HR_MAX);
      if (i_Enable_Toggle)
        o_Enabled <= !o_Enabled;
    end
  end

  // State and counter registers.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: disable > dismiss > snooze > counter expiry > trigger.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (disable_now) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (match && !i_Dismiss) begin
            state_nxt = RINGING;
            cnt_nxt   = RING_LOAD;
          end
        end
        RINGING: begin
          if (i_Dismiss) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (i_Snooze) begin
            state_nxt = SNOOZED;
            cnt_nxt   = SNOOZE_LOAD;
          end else if (i_Sec_Pulse) begin
            if (cnt <= CNT_W'(1)) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt - CNT_W'(1);
            end
          end
        end
        SNOOZED: begin
          if (i_Dismiss) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (i_Sec_Pulse) begin
            if (cnt <= CNT_W'(1)) begin
              state_nxt = RINGING;
              cnt_nxt   = RING_LOAD;
            end else begin
              cnt_nxt = cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_Ringing  = (state == RINGING);
  assign o_Snoozing = (state == SNOOZED);

endmodule

// File: rtl/multi_alarm_controller.sv
// NUM_ALARMS independent alarm channels with select decode, readback mux and combined outputs.
module multi_alarm_controller
  import alarm_clock_pkg::*;
#(
  parameter int NUM_ALARMS     = 4,
  parameter int SNOOZE_MINUTES = 9,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SEL_W          = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Sec_Pulse,
  input  logic [7:0]            i_Time_Hours,
  input  logic [7:0]            i_Time_Minutes,
  input  logic [7:0]            i_Time_Seconds,
  input  logic [SEL_W-1:0]      i_Sel,
  input  logic                  i_Minutes_Inc,
  input  logic                  i_Minutes_Dec,
  input  logic                  i_Hours_Inc,
  input  logic                  i_Hours_Dec,
  input  logic                  i_Enable_Toggle,
  input  logic                  i_Snooze,
  input  logic                  i_Dismiss,
  output logic [7:0]            o_Sel_Hours,
  output logic [7:0]            o_Sel_Minutes,
  output logic [NUM_ALARMS-1:0] o_Enabled,
  output logic [NUM_ALARMS-1:0] o_Ringing,
  output logic                  o_Alarm_On,
  output logic                  o_Snoozing
);

  logic [7:0]            hours_arr   [NUM_ALARMS];
  logic [7:0]            minutes_arr [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] selected;
  logic [NUM_ALARMS-1:0] snoozing;

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_chan
    assign selected[g] = (32'(i_Sel) == g);

    alarm_channel #(
      .SNOOZE_MINUTES(SNOOZE_MINUTES),
      .RING_TIMEOUT_S(RING_TIMEOUT_S)
    ) u_chan (
      .i_Clk          (i_Clk),
      .i_Reset        (i_Reset),
      .i_Sec_Pulse    (i_Sec_Pulse),
      .i_Time_Hours   (i_Time_Hours),
      .i_Time_Minutes (i_Time_Minutes),
      .i_Time_Seconds (i_Time_Seconds),
      .i_Selected     (selected[g]),
      .i_Minutes_Inc  (i_Minutes_Inc),
      .i_Minutes_Dec  (i_Minutes_Dec),
      .i_Hours_Inc    (i_Hours_Inc),
      .i_Hours_Dec    (i_Hours_Dec),
      .i_Enable_Toggle(i_Enable_Toggle),
      .i_Snooze       (i_Snooze),
      .i_Dismiss      (i_Dismiss),
      .o_Hours        (hours_arr[g]),
      .o_Minutes      (minutes_arr[g]),
      .o_Enabled      (o_Enabled[g]),
      .o_Ringing      (o_Ringing[g]),
      .o_Snoozing     (snoozing[g])
    );
  end

  // Readback of the selected channel; an out-of-range select reads 00:00.
  always_comb begin
    o_Sel_Hours   = 8'h00;
    o_Sel_Minutes = 8'h00;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (selected[i]) begin
        o_Sel_Hours   = hours_arr[i];
        o_Sel_Minutes = minutes_arr[i];
      end
    end
  end

  assign o_Alarm_On = |o_Ringing;
  assign o_Snoozing = |snoozing;

endmodule

// File: tb/tb_multi_alarm_controller.sv
// Directed bench for multi_alarm_controller: an edit vector table followed by ring/snooze/dismiss sequences.
`timescale 1ns/1ps
module tb_multi_alarm_controller;

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic       i_Sec_Pulse;
  logic [7:0] i_Time_Hours, i_Time_Minutes, i_Time_Seconds;
  logic [1:0] i_Sel;
  logic       i_Minutes_Inc, i_Minutes_Dec, i_Hours_Inc, i_Hours_Dec;
  logic       i_Enable_Toggle, i_Snooze, i_Dismiss;
  logic [7:0] o_Sel_Hours, o_Sel_Minutes;
  logic [3:0] o_Enabled, o_Ringing;
  logic       o_Alarm_On, o_Snoozing;

  int total = 0;
  int bad   = 0;

  multi_alarm_controller #(
    .NUM_ALARMS(4), .SNOOZE_MINUTES(9), .RING_TIMEOUT_S(60)
  ) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Sec_Pulse(i_Sec_Pulse),
    .i_Time_Hours(i_Time_Hours), .i_Time_Minutes(i_Time_Minutes), .i_Time_Seconds(i_Time_Seconds),
    .i_Sel(i_Sel), .i_Minutes_Inc(i_Minutes_Inc), .i_Minutes_Dec(i_Minutes_Dec),
    .i_Hours_Inc(i_Hours_Inc), .i_Hours_Dec(i_Hours_Dec), .i_Enable_Toggle(i_Enable_Toggle),
    .i_Snooze(i_Snooze), .i_Dismiss(i_Dismiss),
    .o_Sel_Hours(o_Sel_Hours), .o_Sel_Minutes(o_Sel_Minutes), .o_Enabled(o_Enabled),
    .o_Ringing(o_Ringing), .o_Alarm_On(o_Alarm_On), .o_Snoozing(o_Snoozing)
  );

  always #100 i_Clk = ~i_Clk;

  typedef struct {
    string      name;
    logic [1:0] sel;
    logic       mi, md, hi, hd, tog;
    int         rep;
    logic [7:0] exp_h, exp_m;
    logic [3:0] exp_en;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string name, logic [1:0] sel, logic mi, logic md, logic hi,
                              logic hd, logic tog, int rep, logic [7:0] eh, logic [7:0] em,
                              logic [3:0] een);
    vec_t v;
    v.name = name; v.sel = sel; v.mi = mi; v.md = md; v.hi = hi; v.hd = hd; v.tog = tog;
    v.rep = rep; v.exp_h = eh; v.exp_m = em; v.exp_en = een;
    return v;
  endfunction

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sec(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    i_Time_Hours = h; i_Time_Minutes = m; i_Time_Seconds = s;
    i_Sec_Pulse = 1'b1;
    tick();
    i_Sec_Pulse = 1'b0;
  endtask

  task automatic pulse_ctrl(input logic snooze, input logic dismiss);
    i_Snooze = snooze; i_Dismiss = dismiss;
    tick();
    i_Snooze = 1'b0; i_Dismiss = 1'b0;
  endtask

  initial begin
    i_Reset = 1'b1; i_Sec_Pulse = 1'b0;
    i_Time_Hours = 8'h00; i_Time_Minutes = 8'h00; i_Time_Seconds = 8'h00;
    i_Sel = 2'd0; i_Minutes_Inc = 1'b0; i_Minutes_Dec = 1'b0;
    i_Hours_Inc = 1'b0; i_Hours_Dec = 1'b0; i_Enable_Toggle = 1'b0;
    i_Snooze = 1'b0; i_Dismiss = 1'b0;

    vq.push_back(mk("min_inc61",      2'd0, 1,0,0,0,0, 61, 8'h00, 8'h01, 4'b0000));
    vq.push_back(mk("hr_dec_wrap",    2'd0, 0,0,0,1,0,  1, 8'h23, 8'h01, 4'b0000));
    vq.push_back(mk("min_inc_dec",    2'd0, 1,1,0,0,0,  1, 8'h23, 8'h01, 4'b0000));
    vq.push_back(mk("both_fields",    2'd0, 1,0,1,0,0,  1, 8'h00, 8'h02, 4'b0000));
    vq.push_back(mk("min_dec_wrap",   2'd0, 0,1,0,0,0,  3, 8'h00, 8'h59, 4'b0000));
    vq.push_back(mk("hr_inc_carry",   2'd0, 0,0,1,0,0, 11, 8'h11, 8'h59, 4'b0000));
    vq.push_back(mk("hr_dec_borrow",  2'd0, 0,0,0,1,0,  2, 8'h09, 8'h59, 4'b0000));
    vq.push_back(mk("hr_to_12",       2'd0, 0,0,1,0,0,  3, 8'h12, 8'h59, 4'b0000));
    vq.push_back(mk("min_no_carry",   2'd0, 1,0,0,0,0,  1, 8'h12, 8'h00, 4'b0000));
    vq.push_back(mk("ch0_enable",     2'd0, 0,0,0,0,1,  1, 8'h12, 8'h00, 4'b0001));
    vq.push_back(mk("ch3_read",       2'd3, 0,0,0,0,0,  0, 8'h00, 8'h00, 4'b0001));
    vq.push_back(mk("ch3_hours",      2'd3, 0,0,1,0,0, 12, 8'h12, 8'h00, 4'b0001));
    vq.push_back(mk("ch3_enable",     2'd3, 0,0,0,0,1,  1, 8'h12, 8'h00, 4'b1001));
    vq.push_back(mk("ch2_hours",      2'd2, 0,0,1,0,0,  7, 8'h07, 8'h00, 4'b1001));
    vq.push_back(mk("ch2_minutes",    2'd2, 1,0,0,0,0, 30, 8'h07, 8'h30, 4'b1001));
    vq.push_back(mk("ch2_enable",     2'd2, 0,0,0,0,1,  1, 8'h07, 8'h30, 4'b1101));
    vq.push_back(mk("ch1_hours",      2'd1, 0,0,1,0,0,  7, 8'h07, 8'h00, 4'b1101));
    vq.push_back(mk("ch1_minutes",    2'd1, 1,0,0,0,0, 30, 8'h07, 8'h30, 4'b1101));
    vq.push_back(mk("ch1_hr_inc_dec", 2'd1, 0,0,1,1,0,  1, 8'h07, 8'h30, 4'b1101));

    tick(); tick();
    i_Reset = 1'b0;
    chk("rst_ringing",  o_Ringing, 4'b0000);
    chk("rst_alarm_on", o_Alarm_On, 1'b0);
    chk("rst_snoozing", o_Snoozing, 1'b0);
    chk("rst_enabled",  o_Enabled, 4'b0000);
    chk("rst_sel_time", {o_Sel_Hours, o_Sel_Minutes}, 16'h0000);

    foreach (vq[k]) begin
      i_Sel = vq[k].sel;
      if (vq[k].rep == 0) tick();
      for (int r = 0; r < vq[k].rep; r++) begin
        i_Minutes_Inc = vq[k].mi; i_Minutes_Dec = vq[k].md;
        i_Hours_Inc = vq[k].hi; i_Hours_Dec = vq[k].hd; i_Enable_Toggle = vq[k].tog;
        tick();
        i_Minutes_Inc = 1'b0; i_Minutes_Dec = 1'b0;
        i_Hours_Inc = 1'b0; i_Hours_Dec = 1'b0; i_Enable_Toggle = 1'b0;
      end
      chk({vq[k].name, "_hours"},   o_Sel_Hours, vq[k].exp_h);
      chk({vq[k].name, "_minutes"}, o_Sel_Minutes, vq[k].exp_m);
      chk({vq[k].name, "_enabled"}, o_Enabled, vq[k].exp_en);
    end

    // Matching minute but seconds not 00 does not trigger.
    sec(8'h07, 8'h30, 8'h59);
    chk("no_trig_sec59", o_Ringing, 4'b0000);

    // Channel 2 rings; channel 1 at the same time is disabled.
    sec(8'h07, 8'h30, 8'h00);
    chk("trig_ringing",  o_Ringing, 4'b0100);
    chk("trig_alarm_on", o_Alarm_On, 1'b1);

    // Snooze, then 539 pulses keep it silent, the 540th brings it back.
    pulse_ctrl(1'b1, 1'b0);
    chk("snooze_ringing",  o_Ringing, 4'b0000);
    chk("snooze_snoozing", o_Snoozing, 1'b1);
    for (int p = 0; p < 539; p++) begin
      sec(8'h07, 8'h30, 8'h15);
      tick();
    end
    chk("snooze_539_ringing",  o_Ringing, 4'b0000);
    chk("snooze_539_snoozing", o_Snoozing, 1'b1);
    sec(8'h07, 8'h30, 8'h15);
    chk("snooze_540_ringing",  o_Ringing, 4'b0100);
    chk("snooze_540_snoozing", o_Snoozing, 1'b0);

    // Ignored snooze while snoozed is not testable here; auto-dismiss after 60 pulses.
    for (int p = 0; p < 59; p++) sec(8'h07, 8'h31, 8'h20);
    chk("timeout_59_ringing", o_Ringing, 4'b0100);
    sec(8'h07, 8'h31, 8'h20);
    chk("timeout_60_ringing",  o_Ringing, 4'b0000);
    chk("timeout_60_snoozing", o_Snoozing, 1'b0);
    chk("timeout_60_alarm_on", o_Alarm_On, 1'b0);
    sec(8'h07, 8'h31, 8'h00);
    chk("no_retrig_0731", o_Ringing, 4'b0000);

    // Dismiss within the matching minute does not re-trigger at seconds 01.
    sec(8'h07, 8'h30, 8'h00);
    chk("retrig_ringing", o_Ringing, 4'b0100);
    pulse_ctrl(1'b0, 1'b1);
    chk("dismiss_ringing", o_Ringing, 4'b0000);
    sec(8'h07, 8'h30, 8'h01);
    chk("dismiss_no_retrig", o_Ringing, 4'b0000);

    // Two channels ring together; dismiss beats snooze.
    sec(8'h12, 8'h00, 8'h00);
    chk("multi_ringing",  o_Ringing, 4'b1001);
    chk("multi_alarm_on", o_Alarm_On, 1'b1);
    pulse_ctrl(1'b1, 1'b1);
    chk("dismiss_wins_ringing",  o_Ringing, 4'b0000);
    chk("dismiss_wins_snoozing", o_Snoozing, 1'b0);

    // Disable of channel 0 beats snooze; channel 3 snoozes.
    sec(8'h12, 8'h00, 8'h00);
    chk("multi2_ringing", o_Ringing, 4'b1001);
    i_Sel = 2'd0; i_Enable_Toggle = 1'b1; i_Snooze = 1'b1;
    tick();
    i_Enable_Toggle = 1'b0; i_Snooze = 1'b0;
    chk("disable_ringing",  o_Ringing, 4'b0000);
    chk("disable_snoozing", o_Snoozing, 1'b1);
    chk("disable_enabled",  o_Enabled, 4'b1100);
    pulse_ctrl(1'b0, 1'b1);
    chk("dismiss_snoozed", o_Snoozing, 1'b0);

    // Reset while ringing clears everything.
    sec(8'h12, 8'h00, 8'h00);
    chk("pre_reset_ringing", o_Ringing, 4'b1000);
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    chk("reset_ringing",  o_Ringing, 4'b0000);
    chk("reset_alarm_on", o_Alarm_On, 1'b0);
    chk("reset_snoozing", o_Snoozing, 1'b0);
    chk("reset_enabled",  o_Enabled, 4'b0000);
    for (int c = 0; c < 4; c++) begin
      i_Sel = 2'(c);
      #1;
      chk($sformatf("reset_time_ch%0d", c), {o_Sel_Hours, o_Sel_Minutes}, 16'h0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
